// File: rtl/filter_sequencer.sv
// Sequences up to four cascaded biquad stages over a shared external MAC for one audio sample.
// Optional FILTER_SEQ_SAT_EN: saturate stage results to the Q1.15 range instead of wrapping.
module filter_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic [3:0]  stage_bypass,
    input  logic [31:0] mac_result,
    output logic [1:0]  stage_sel,
    output logic [2:0]  tap_sel,
    output logic [4:0]  coef_addr,
    output logic        mac_en,
    output logic        mac_clr,
    output logic [15:0] stage_x0,
    output logic        hist_we,
    output logic [15:0] stage_y,
    output logic [15:0] sample_out,
    output logic        sample_out_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned SampleW = 16;
    localparam int unsigned AccW    = 32;
    localparam int unsigned TapsPerStage = 5;
    localparam logic [2:0]  LastTap  = 3'(TapsPerStage - 1);
    localparam logic [1:0]  LastStage = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ENTER,
        MAC,
        WAIT,
        STORE,
        DONE
    } state_t;

    state_t state, stateNxt;

    logic [1:0]         stageSelNxt;
    logic [2:0]         tapSelNxt;
    logic [4:0]         coefAddrNxt;
    logic               macEnNxt;
    logic               macClrNxt;
    logic [SampleW-1:0] x0Nxt;
    logic               histWeNxt;
    logic [SampleW-1:0] yNxt;
    logic [SampleW-1:0] outNxt;
    logic               outValidNxt;
    logic               busyNxt;
    logic               overrunNxt;

    // Bits outside the Q1.15 window only matter for saturation.
    logic unusedMacBits;
    assign unusedMacBits = ^{mac_result[31:30], mac_result[13:0]};

    // Q3.29 accumulator to Q1.15 stage result.
    function automatic logic [SampleW-1:0] postProc(input logic [AccW-1:0] acc);
`ifdef FILTER_SEQ_SAT_EN
        if (acc[31:29] == 3'b000 || acc[31:29] == 3'b111) begin
            return acc[29:14];
        end else if (acc[31]) begin
            return 16'h8000;
        end else begin
            return 16'h7FFF;
        end
`else
        return acc[29:14];
`endif
    endfunction

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            stage_sel        <= '0;
            tap_sel          <= '0;
            coef_addr        <= '0;
            mac_en           <= 1'b0;
            mac_clr          <= 1'b0;
            stage_x0         <= '0;
            hist_we          <= 1'b0;
            stage_y          <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            state            <= stateNxt;
            stage_sel        <= stageSelNxt;
            tap_sel          <= tapSelNxt;
            coef_addr        <= coefAddrNxt;
            mac_en           <= macEnNxt;
            mac_clr          <= macClrNxt;
            stage_x0         <= x0Nxt;
            hist_we          <= histWeNxt;
            stage_y          <= yNxt;
            sample_out       <= outNxt;
            sample_out_valid <= outValidNxt;
            busy             <= busyNxt;
            overrun          <= overrunNxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        stateNxt    = state;
        stageSelNxt = stage_sel;
        tapSelNxt   = tap_sel;
        macEnNxt    = 1'b0;
        macClrNxt   = 1'b0;
        x0Nxt       = stage_x0;
        histWeNxt   = 1'b0;
        yNxt        = stage_y;
        outNxt      = sample_out;
        outValidNxt = 1'b0;
        overrunNxt  = overrun | (sample_valid && state != IDLE);

        case (state)
            IDLE: begin
                if (sample_valid) begin
                    x0Nxt       = sample_in;
                    stageSelNxt = 2'd0;
                    tapSelNxt   = 3'd0;
                    stateNxt    = ENTER;
                end
            end
            ENTER: begin
                if (stage_bypass[stage_sel]) begin
                    tapSelNxt = 3'd0;
                    if (stage_sel == LastStage) begin
                        stateNxt = DONE;
                    end else begin
                        stageSelNxt = stage_sel + 2'd1;
                        stateNxt    = ENTER;
                    end
                end else begin
                    tapSelNxt = 3'd0;
                    macEnNxt  = 1'b1;
                    macClrNxt = 1'b1;
                    stateNxt  = MAC;
                end
            end
            MAC: begin
                if (tap_sel == LastTap) begin
                    stateNxt = WAIT;
                end else begin
                    tapSelNxt = tap_sel + 3'd1;
                    macEnNxt  = 1'b1;
                end
            end
            WAIT: begin
                // MAC output is final here and held until the next clear.
                yNxt      = postProc(mac_result);
                histWeNxt = 1'b1;
                stateNxt  = STORE;
            end
            STORE: begin
                x0Nxt     = stage_y;
                tapSelNxt = 3'd0;
                if (stage_sel == LastStage) begin
                    stateNxt = DONE;
                end else begin
                    stageSelNxt = stage_sel + 2'd1;
                    stateNxt    = ENTER;
                end
            end
            DONE: begin
                outNxt      = stage_x0;
                outValidNxt = 1'b1;
                stateNxt    = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        coefAddrNxt = 5'(stageSelNxt) * 5'(TapsPerStage) + 5'(tapSelNxt);
        busyNxt     = (stateNxt != IDLE);
    end

endmodule
